// File: rtl/ram_loader_if.sv
// ----------------------------------------------------------------------------
// ram_loader_if : source-stream, RAM-port and status bundle for ram_loader
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ram_loader_if;
  logic       start;
  logic [7:0] length;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_write_enable;
  logic [7:0] mem_address;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;
  logic       busy;
  logic       done;
  logic [7:0] checksum;
  logic       error;

  // The loader itself.
  modport slave (
    input  start, length, in_valid, in_data, mem_data_out,
    output in_ready, mem_write_enable, mem_address, mem_data_in,
           busy, done, checksum, error
  );

  // Whoever drives the loader and models the RAM.
  modport master (
    output start, length, in_valid, in_data, mem_data_out,
    input  in_ready, mem_write_enable, mem_address, mem_data_in,
           busy, done, checksum, error
  );
endinterface

`default_nettype wire

// File: rtl/ram_loader.sv
// ----------------------------------------------------------------------------
// ram_loader : streams bytes into a RAM, then reads them back to verify a sum
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ram_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  wire          clk,
  input  wire          rst,
  ram_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] count_q, count_d;
  logic [7:0] checksum_q, checksum_d;
  logic [7:0] readsum_q, readsum_d;
  logic       error_q, error_d;
  logic       rd_pend_q, rd_pend_d;

  logic       w_in_ready;
  logic       w_we;
  logic [7:0] w_addr;
  logic [7:0] w_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= 8'h00;
      count_q    <= 8'h00;
      checksum_q <= 8'h00;
      readsum_q  <= 8'h00;
      error_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      checksum_q <= checksum_d;
      readsum_q  <= readsum_d;
      error_q    <= error_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    checksum_d = checksum_q;
    readsum_d  = readsum_q;
    error_d    = error_q;
    rd_pend_d  = 1'b0;
    w_in_ready = 1'b0;
    w_we       = 1'b0;
    w_addr     = 8'h00;
    w_wdata    = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d      = bus.length;
          count_d    = 8'h00;
          checksum_d = 8'h00;
          readsum_d  = 8'h00;
          error_d    = 1'b0;
          state_d    = (bus.length == 8'h00) ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        w_in_ready = 1'b1;
        w_we       = bus.in_valid;
        w_addr     = BASE_ADDR + count_q;
        w_wdata    = bus.in_data;
        if (bus.in_valid) begin
          checksum_d = checksum_q + bus.in_data;
          if (count_q == len_q - 8'd1) begin
            count_d = 8'h00;
            state_d = S_VERIFY;
          end else begin
            count_d = count_q + 8'd1;
          end
        end
      end

      S_VERIFY: begin
        // Addresses go out while count < length; data returns one cycle later,
        // so the final cycle issues nothing and only captures the last byte.
        w_addr = BASE_ADDR + count_q;
        if (count_q != len_q) begin
          count_d   = count_q + 8'd1;
          rd_pend_d = 1'b1;
        end
        if (rd_pend_q) begin
          readsum_d = readsum_q + bus.mem_data_out;
        end
        if (count_q == len_q) begin
          error_d = (readsum_d != checksum_q);
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.in_ready         = w_in_ready;
  assign bus.mem_write_enable = w_we;
  assign bus.mem_address      = w_addr;
  assign bus.mem_data_in      = w_wdata;
  assign bus.busy             = (state_q != S_IDLE);
  assign bus.done             = (state_q == S_DONE);
  assign bus.checksum         = checksum_q;
  assign bus.error            = error_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_loader.sv
// ----------------------------------------------------------------------------
// tb_ram_loader : directed checks of ram_loader at base 0x00 and base 0xFE
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ram_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] length;
  logic       in_valid;
  logic [7:0] in_data;
  logic       corrupt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_loader_if if0 ();
  ram_loader_if if1 ();

  // Both loaders see the same stream; each owns a RAM model.
  assign if0.start = start;  assign if0.length = length;
  assign if0.in_valid = in_valid;  assign if0.in_data = in_data;
  assign if1.start = start;  assign if1.length = length;
  assign if1.in_valid = in_valid;  assign if1.in_data = in_data;

  ram_loader #(.BASE_ADDR(8'h00)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  ram_loader #(.BASE_ADDR(8'hFE)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  logic [7:0] ram0 [256];
  logic [7:0] ram1 [256];
  logic [7:0] rd0, rd1;
  int wr0 = 0, wr1 = 0, dn0 = 0, dn1 = 0;

  assign if0.mem_data_out = rd0;
  assign if1.mem_data_out = rd1;

  always @(posedge clk) begin
    if (if0.mem_write_enable) begin ram0[if0.mem_address] <= if0.mem_data_in; wr0 <= wr0 + 1; end
    if (if1.mem_write_enable) begin ram1[if1.mem_address] <= if1.mem_data_in; wr1 <= wr1 + 1; end
    rd0 <= (corrupt && if0.mem_address == 8'h01) ? 8'h00 : ram0[if0.mem_address];
    rd1 <= ram1[if1.mem_address];
    if (if0.done) dn0 <= dn0 + 1;
    if (if1.done) dn1 <= dn1 + 1;
  end

  logic [7:0] bseq [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer; vpat bit k is in_valid in the k-th LOAD cycle.
  // cyc counts cycles after the edge that sampled start, up to done.
  task automatic run_load(input logic [7:0] len, input logic [7:0] vpat, output int cyc);
    int nacc;
    int k;
    logic [7:0] a1;
    start = 1'b1; length = len; in_valid = 1'b0;
    tick();
    start = 1'b0;
    cyc = 1; nacc = 0; k = 0;
    while (nacc < int'(len) && k < 40) begin
      in_valid = vpat[k % 8];
      in_data  = bseq[nacc];
      #1;
      if (in_valid) begin
        a1 = 8'hFE + nacc[7:0];
        chk("load_we", {7'd0, if0.mem_write_enable}, 8'd1);
        chk("load_addr0", if0.mem_address, nacc[7:0]);
        chk("load_addr1", if1.mem_address, a1);
        chk("load_din", if0.mem_data_in, bseq[nacc]);
      end else begin
        chk("stall_we", {7'd0, if0.mem_write_enable}, 8'd0);
      end
      tick();
      cyc++;
      if (in_valid) nacc++;
      k++;
    end
    in_valid = 1'b0; in_data = 8'h00;
    while (!if0.done && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("done_seen", {7'd0, if0.done}, 8'd1);
  endtask

  int cyc;
  int w0, d0;

  initial begin
    rst = 1'b1; start = 1'b0; length = 8'h00; in_valid = 1'b0; in_data = 8'h00; corrupt = 1'b0;
    tick(); tick();
    chk("rst_busy", {7'd0, if0.busy}, 8'd0);
    chk("rst_done", {7'd0, if0.done}, 8'd0);
    chk("rst_ready", {7'd0, if0.in_ready}, 8'd0);
    chk("rst_addr", if0.mem_address, 8'h00);
    chk("rst_cks", if0.checksum, 8'h00);
    chk("rst_err", {7'd0, if0.error}, 8'd0);
    rst = 1'b0;
    tick();

    // Back-to-back bytes FF,AA,F0.
    bseq[0] = 8'hFF; bseq[1] = 8'hAA; bseq[2] = 8'hF0; bseq[3] = 8'h00;
    w0 = wr0; d0 = dn0;
    run_load(8'd3, 8'hFF, cyc);
    chk("b2b_latency", cyc[7:0], 8'd8);
    chk("b2b_cks", if0.checksum, 8'h99);
    chk("b2b_err", {7'd0, if0.error}, 8'd0);
    chk("b2b_busy_done", {7'd0, if0.busy}, 8'd1);
    tick();
    chk("b2b_done_once", {7'd0, if0.done}, 8'd0);
    chk("b2b_idle", {7'd0, if0.busy}, 8'd0);
    chk("b2b_ndone", 8'(dn0 - d0), 8'd1);
    chk("b2b_nwr", 8'(wr0 - w0), 8'd3);
    chk("b2b_ram0", ram0[0], 8'hFF);
    chk("b2b_ram1", ram0[1], 8'hAA);
    chk("b2b_ram2", ram0[2], 8'hF0);

    // Same bytes with in_valid toggling 1,0,1,0,1.
    w0 = wr0;
    run_load(8'd3, 8'b0001_0101, cyc);
    chk("stall_cks", if0.checksum, 8'h99);
    chk("stall_err", {7'd0, if0.error}, 8'd0);
    tick();
    chk("stall_nwr", 8'(wr0 - w0), 8'd3);

    // Base 0xFE wraps through 0xFF to 0x00.
    bseq[0] = 8'h01; bseq[1] = 8'h02; bseq[2] = 8'h03;
    run_load(8'd3, 8'hFF, cyc);
    chk("wrap_cks", if1.checksum, 8'h06);
    chk("wrap_err", {7'd0, if1.error}, 8'd0);
    tick();
    chk("wrap_ramFE", ram1[8'hFE], 8'h01);
    chk("wrap_ramFF", ram1[8'hFF], 8'h02);
    chk("wrap_ram00", ram1[8'h00], 8'h03);

    // Readback corruption at address 1 on the base-0 loader only.
    bseq[0] = 8'h11; bseq[1] = 8'h22; bseq[2] = 8'h33;
    corrupt = 1'b1;
    d0 = dn0;
    run_load(8'd3, 8'hFF, cyc);
    chk("corr_cks", if0.checksum, 8'h66);
    chk("corr_err0", {7'd0, if0.error}, 8'd1);
    chk("corr_err1", {7'd0, if1.error}, 8'd0);
    tick();
    corrupt = 1'b0;
    chk("corr_err_held", {7'd0, if0.error}, 8'd1);
    chk("corr_ndone", 8'(dn0 - d0), 8'd1);

    // Empty transfer.
    w0 = wr0;
    run_load(8'd0, 8'h00, cyc);
    chk("len0_latency", cyc[7:0], 8'd1);
    chk("len0_cks", if0.checksum, 8'h00);
    chk("len0_err", {7'd0, if0.error}, 8'd0);
    tick();
    chk("len0_nwr", 8'(wr0 - w0), 8'd0);

    // Reset after two bytes of a four-byte load.
    w0 = wr0; d0 = dn0;
    start = 1'b1; length = 8'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h44;
    tick();
    in_data = 8'h55;
    tick();
    in_data = 8'h77;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {7'd0, if0.busy}, 8'd0);
    chk("arst_done", {7'd0, if0.done}, 8'd0);
    chk("arst_ready", {7'd0, if0.in_ready}, 8'd0);
    chk("arst_we", {7'd0, if0.mem_write_enable}, 8'd0);
    chk("arst_addr", if0.mem_address, 8'h00);
    chk("arst_din", if0.mem_data_in, 8'h00);
    chk("arst_cks", if0.checksum, 8'h00);
    chk("arst_err", {7'd0, if0.error}, 8'd0);
    tick(); tick();
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("arst_nwr", 8'(wr0 - w0), 8'd2);
    chk("arst_nodone", 8'(dn0 - d0), 8'd0);
    bseq[0] = 8'h05; bseq[1] = 8'h06;
    run_load(8'd2, 8'hFF, cyc);
    chk("post_latency", cyc[7:0], 8'd6);
    chk("post_cks", if0.checksum, 8'h0B);
    chk("post_err", {7'd0, if0.error}, 8'd0);
    tick();
    chk("post_ram0", ram0[0], 8'h05);
    chk("post_ram1", ram0[1], 8'h06);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter: BASE_ADDR, 8'h00, first RAM address written/read; addresses wrap modulo 256.
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port: rst  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have port: start  in  1  one-cycle request to begin a load; sampled in IDLE only.
REQ-005 SHALL have port: length  in  8  byte count, sampled with start; 0 = empty transfer.
REQ-006 SHALL have port: in_valid  in  1  source byte available.
REQ-007 SHALL have port: in_data  in  8  source byte.
REQ-008 SHALL have port: in_ready  out  1  loader accepts byte this cycle.
REQ-009 SHALL have port: mem_write_enable  out  1  drives RAM write_enable.
REQ-010 SHALL have port: mem_address  out  8  drives RAM address.
REQ-011 SHALL have port: mem_data_in  out  8  drives RAM data_in.
REQ-012 SHALL have port: mem_data_out  in  8  RAM data_out; registered read, valid one cycle after address.
REQ-013 SHALL have port: busy  out  1  high in any state except IDLE.
REQ-014 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-015 SHALL have port: checksum  out  8  mod-256 sum of bytes accepted; held until next start.
REQ-016 SHALL have port: error  out  1  readback sum != checksum; held until next start.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, VERIFY, DONE.
REQ-018 IDLE: start=1 captures length, clears count, sums, error, checksum; length!=0 -> LOAD, length==0 -> DONE.
REQ-019 IDLE/VERIFY/DONE: in_ready=0, mem_write_enable=0; start ignored outside IDLE.
REQ-020 LOAD: in_ready=1; mem_write_enable=in_valid; mem_address=BASE_ADDR+count; mem_data_in=in_data (combinational, write on same edge).
REQ-021 LOAD handshake (in_valid&in_ready at posedge): count+1, checksum+=in_data mod 256; in_valid=0 stalls with no write, no count change.
REQ-022 LOAD: handshake with count==length-1 -> VERIFY, count cleared.
REQ-023 VERIFY: mem_address=BASE_ADDR+count, one address per cycle, count+1 each cycle until length addresses issued.
REQ-024 VERIFY: readback sum accumulates mem_data_out one cycle after each address (pipeline delay 1); exactly length bytes summed.
REQ-025 VERIFY -> DONE on cycle after last byte captured; error=(readsum!=checksum) registered on that transition.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE.
REQ-027 Latency: N-byte load with in_valid held high = N LOAD cycles + N+1 VERIFY cycles + 1 DONE cycle.
REQ-028 length==0: no writes, no reads, checksum=0, error=0, done one cycle after start.
REQ-029 Address wrap: BASE_ADDR+count computed in 8 bits (0xFF -> 0x00); length 256 not representable.

Reset
REQ-030 rst=1 SHALL immediately force IDLE; busy, done, in_ready, mem_write_enable, error =0; mem_address, mem_data_in, checksum =8'h00; count, sums cleared.
REQ-031 Reset mid-LOAD or mid-VERIFY SHALL abort with no further writes and no done pulse; RAM contents already written untouched.

Verification
REQ-032 BASE_ADDR=0, start length=3, bytes FF,AA,F0 valid back-to-back -> writes 0x00=FF,0x01=AA,0x02=F0; checksum=0x99, error=0, done 8 cycles after first accept.
REQ-033 length=3, in_valid toggled 1,0,1,0,1 -> only 3 writes, no write while in_valid=0, same checksum 0x99.
REQ-034 BASE_ADDR=8'hFE, length=3, bytes 01,02,03 -> writes to 0xFE,0xFF,0x00; checksum=0x06.
REQ-035 Readback corruption: bench RAM model returns 0x00 for address 1 in VERIFY -> error=1, done pulses once.
REQ-036 start with length=0 -> done one cycle later, no mem_write_enable, checksum=0x00, error=0.
REQ-037 rst asserted mid-LOAD after 2 bytes -> all outputs at reset values same cycle, busy=0, no done; new start afterwards completes normally.
